// File: rtl/usb_pd_pkg.sv
// Shared USB PD line-coding definitions: 4b5b table, K-codes, CRC-32 and FSM states.
package usb_pd_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PREAMBLE = 3'd1,
    S_SOP      = 3'd2,
    S_DATA     = 3'd3,
    S_CRC      = 3'd4,
    S_EOP      = 3'd5,
    S_TAIL     = 3'd6
  } pd_state_e;

  // K-codes, bit 0 goes on the line first
  localparam logic [4:0]  SYNC1 = 5'b11000;
  localparam logic [4:0]  SYNC2 = 5'b10001;
  localparam logic [4:0]  EOP   = 5'b01101;

  localparam logic [31:0] CRC32_POLY = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT = 32'hFFFFFFFF;

  localparam int PREAMBLE_BITS = 64;

  function automatic logic [4:0] enc4b5b(input logic [3:0] nib);
    logic [4:0] sym;
    case (nib)
      4'h0: sym = 5'b11110;
      4'h1: sym = 5'b01001;
      4'h2: sym = 5'b10100;
      4'h3: sym = 5'b10101;
      4'h4: sym = 5'b01010;
      4'h5: sym = 5'b01011;
      4'h6: sym = 5'b01110;
      4'h7: sym = 5'b01111;
      4'h8: sym = 5'b10010;
      4'h9: sym = 5'b10011;
      4'hA: sym = 5'b10110;
      4'hB: sym = 5'b10111;
      4'hC: sym = 5'b11010;
      4'hD: sym = 5'b11011;
      4'hE: sym = 5'b11100;
      4'hF: sym = 5'b11101;
      default: sym = 5'b11110;
    endcase
    return sym;
  endfunction

  // Reflected CRC-32, one byte, data consumed LSB first
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'h000000, data};
    for (int i = 0; i < 8; i++) begin
      if (c[0]) c = (c >> 1) ^ CRC32_POLY;
      else      c = c >> 1;
    end
    return c;
  endfunction

endpackage

// File: rtl/usb_pd_encode_if.sv
// Message-source side of the PD encoder: start request, byte stream and status.
interface usb_pd_encode_if;
  logic       start;
  logic [7:0] data_in;
  logic       data_valid;
  logic       data_last;
  logic       data_ready;
  logic       busy;
  logic       underrun;

  modport master (
    output start, data_in, data_valid, data_last,
    input  data_ready, busy, underrun
  );

  modport slave (
    input  start, data_in, data_valid, data_last,
    output data_ready, busy, underrun
  );
endinterface

// File: rtl/usb_pd_crc32.sv
// Byte-wide CRC-32 accumulator; init presets, en folds in one byte.
module usb_pd_crc32
  import usb_pd_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        init_i,
  input  logic        en_i,
  input  logic [7:0]  data_i,
  output logic [31:0] crc_o
);
  logic [31:0] crc_q;
  logic [31:0] crc_d;

  // Next CRC value: preset has priority over a byte update
  always_comb begin
    crc_d = crc_q;
    if (init_i)    crc_d = CRC32_INIT;
    else if (en_i) crc_d = crc32_byte(crc_q, data_i);
    else           crc_d = crc_q;
  end

  // CRC register
  always_ff @(posedge clk_i) begin
    if (rst_i) crc_q <= CRC32_INIT;
    else       crc_q <= crc_d;
  end

  assign crc_o = crc_q;
endmodule

// File: rtl/usb_pd_encode.sv
// USB PD BMC transmitter: preamble, SOP, 4b5b payload, CRC-32, EOP and line release tail.
module usb_pd_encode
  import usb_pd_pkg::*;
#(
  parameter int BIT_CLKS = 90
)(
  input  logic           clk_i,
  input  logic           rst_i,
  usb_pd_encode_if.slave bus,
  output logic           cc_out_o,
  output logic           cc_oe_o
);
  localparam int PH_W = $clog2(BIT_CLKS);
  localparam logic [PH_W-1:0] PH_ONE  = PH_W'(1);
  localparam logic [PH_W-1:0] PH_MID  = PH_W'(BIT_CLKS / 2 - 1);
  localparam logic [PH_W-1:0] PH_HALF = PH_W'(BIT_CLKS / 2);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(BIT_CLKS - 1);

  pd_state_e       state_q, state_d;
  logic [PH_W-1:0] ph_q, ph_d;       // cycle within the bit cell
  logic [5:0]      cnt_q, cnt_d;     // preamble bit / SOP code / CRC nibble counter
  logic [4:0]      sym_q, sym_d;     // symbol shifter, bit 0 is on the line
  logic [2:0]      bidx_q, bidx_d;   // bit index within symbol
  logic            nib_q, nib_d;     // 0: low nibble of byte, 1: high nibble
  logic [3:0]      hi_q, hi_d;       // high nibble waiting to be sent
  logic            last_q, last_d;
  logic            fetch_q, fetch_d; // first cycle of a byte: fetch from source
  logic            cc_out_q, cc_out_d;
  logic            cc_oe_q, cc_oe_d;
  logic            busy_q, busy_d;

  logic            cur_bit_s;
  logic            crc_en_s;
  logic            crc_init_s;
  logic [31:0]     crc_s;
  logic [31:0]     crc_tx_s;
  logic [2:0]      nidx_s;

  assign crc_init_s = (state_q == S_IDLE);
  assign crc_tx_s   = ~crc_s;
  assign nidx_s     = cnt_q[2:0] + 3'd1;
  assign cur_bit_s  = (state_q == S_PREAMBLE) ? cnt_q[0] : sym_q[0];

  usb_pd_crc32 u_crc (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .init_i (crc_init_s),
    .en_i   (crc_en_s),
    .data_i (bus.data_in),
    .crc_o  (crc_s)
  );

  // FSM state register
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next state and datapath: BMC cell timing, symbol sequencing, byte fetch
  always_comb begin
    state_d  = state_q;
    ph_d     = ph_q;
    cnt_d    = cnt_q;
    sym_d    = sym_q;
    bidx_d   = bidx_q;
    nib_d    = nib_q;
    hi_d     = hi_q;
    last_d   = last_q;
    fetch_d  = 1'b0;
    cc_out_d = cc_out_q;
    cc_oe_d  = cc_oe_q;
    busy_d   = busy_q;
    crc_en_s = 1'b0;
    case (state_q)
      S_IDLE: begin
        ph_d     = '0;
        cnt_d    = 6'd0;
        bidx_d   = 3'd0;
        nib_d    = 1'b0;
        cc_out_d = 1'b0;
        cc_oe_d  = 1'b0;
        busy_d   = 1'b0;
        if (bus.start) begin
          // first preamble boundary: line rises on the very next cycle
          state_d  = S_PREAMBLE;
          cc_out_d = 1'b1;
          cc_oe_d  = 1'b1;
          busy_d   = 1'b1;
        end else begin
          state_d  = S_IDLE;
        end
      end
      S_TAIL: begin
        ph_d = ph_q + PH_ONE;
        if (ph_q == PH_MID) cc_out_d = 1'b0;
        else                cc_out_d = cc_out_q;
        if (ph_q == PH_LAST) begin
          state_d  = S_IDLE;
          ph_d     = '0;
          cc_out_d = 1'b0;
          cc_oe_d  = 1'b0;
          busy_d   = 1'b0;
        end else begin
          state_d  = S_TAIL;
        end
      end
      S_PREAMBLE, S_SOP, S_DATA, S_CRC, S_EOP: begin
        ph_d = ph_q + PH_ONE;
        if (ph_q == PH_MID && cur_bit_s) cc_out_d = ~cc_out_q;
        else                             cc_out_d = cc_out_q;
        // the first bit's level only matters at mid-cell, so fetching during cycle 0 is in time
        if (fetch_q) begin
          bidx_d = 3'd0;
          nib_d  = 1'b0;
          if (bus.data_valid) begin
            hi_d     = bus.data_in[7:4];
            last_d   = bus.data_last;
            sym_d    = enc4b5b(bus.data_in[3:0]);
            crc_en_s = 1'b1;
          end else begin
            state_d  = S_EOP;
            sym_d    = EOP;
          end
        end else begin
          crc_en_s = 1'b0;
        end
        if (ph_q == PH_LAST) begin
          ph_d     = '0;
          cc_out_d = ~cc_out_q;
          if (state_q != S_PREAMBLE && bidx_q != 3'd4) begin
            sym_d  = {1'b0, sym_q[4:1]};
            bidx_d = bidx_q + 3'd1;
          end else begin
            bidx_d = 3'd0;
            case (state_q)
              S_PREAMBLE: begin
                if (cnt_q == 6'(PREAMBLE_BITS - 1)) begin
                  state_d = S_SOP;
                  cnt_d   = 6'd0;
                  sym_d   = SYNC1;
                end else begin
                  cnt_d   = cnt_q + 6'd1;
                end
              end
              S_SOP: begin
                if (cnt_q == 6'd3) begin
                  state_d = S_DATA;
                  fetch_d = 1'b1;
                  nib_d   = 1'b0;
                end else begin
                  cnt_d   = cnt_q + 6'd1;
                  sym_d   = (cnt_q == 6'd2) ? SYNC2 : SYNC1;
                end
              end
              S_DATA: begin
                if (!nib_q) begin
                  sym_d   = enc4b5b(hi_q);
                  nib_d   = 1'b1;
                end else if (last_q) begin
                  state_d = S_CRC;
                  cnt_d   = 6'd0;
                  sym_d   = enc4b5b(crc_tx_s[3:0]);
                end else begin
                  fetch_d = 1'b1;
                  nib_d   = 1'b0;
                end
              end
              S_CRC: begin
                if (cnt_q == 6'd7) begin
                  state_d = S_EOP;
                  sym_d   = EOP;
                end else begin
                  cnt_d   = cnt_q + 6'd1;
                  sym_d   = enc4b5b(crc_tx_s[{nidx_s, 2'b00} +: 4]);
                end
              end
              S_EOP: begin
                // no boundary toggle after the final bit; a high line is held half a cell first
                state_d  = S_TAIL;
                cc_out_d = cc_out_q;
                ph_d     = cc_out_q ? '0 : PH_HALF;
              end
              default: begin
                state_d = S_IDLE;
              end
            endcase
          end
        end else begin
          cc_out_d = cc_out_d;
        end
      end
      default: begin
        state_d  = S_IDLE;
        cc_out_d = 1'b0;
        cc_oe_d  = 1'b0;
        busy_d   = 1'b0;
      end
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ph_q     <= '0;
      cnt_q    <= 6'd0;
      sym_q    <= 5'd0;
      bidx_q   <= 3'd0;
      nib_q    <= 1'b0;
      hi_q     <= 4'd0;
      last_q   <= 1'b0;
      fetch_q  <= 1'b0;
      cc_out_q <= 1'b0;
      cc_oe_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      ph_q     <= ph_d;
      cnt_q    <= cnt_d;
      sym_q    <= sym_d;
      bidx_q   <= bidx_d;
      nib_q    <= nib_d;
      hi_q     <= hi_d;
      last_q   <= last_d;
      fetch_q  <= fetch_d;
      cc_out_q <= cc_out_d;
      cc_oe_q  <= cc_oe_d;
      busy_q   <= busy_d;
    end
  end

  // Handshake outputs: ready/underrun are decided in the fetch cycle itself
  always_comb begin
    bus.data_ready = 1'b0;
    bus.underrun   = 1'b0;
    if (fetch_q && !rst_i) begin
      bus.data_ready = bus.data_valid;
      bus.underrun   = ~bus.data_valid;
    end else begin
      bus.data_ready = 1'b0;
      bus.underrun   = 1'b0;
    end
  end

  assign bus.busy = busy_q;
  assign cc_out_o = cc_out_q;
  assign cc_oe_o  = cc_oe_q;
endmodule

// File: tb/tb_usb_pd_encode.sv
// Self-checking bench for usb_pd_encode: waveform reference built from the frame rules.
module tb_usb_pd_encode;
  localparam int B = 90;
  localparam int H = B / 2;
  localparam logic [4:0] K_SYNC1 = 5'b11000;
  localparam logic [4:0] K_SYNC2 = 5'b10001;
  localparam logic [4:0] K_EOP   = 5'b01101;

  logic clk = 1'b0;
  logic rst;
  logic cc_out, cc_oe;
  always #5 clk = ~clk;

  usb_pd_encode_if bus();

  usb_pd_encode #(.BIT_CLKS(B)) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .bus      (bus),
    .cc_out_o (cc_out),
    .cc_oe_o  (cc_oe)
  );

  int checks = 0;
  int errors = 0;
  logic [7:0] payload [16];
  logic exp_bits [$];
  logic exp_lvl  [$];
  logic obs      [$];
  logic [31:0] last_crc_dec;

  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  function automatic logic [4:0] enc(input logic [3:0] v);
    logic [4:0] t [16];
    t = '{5'b11110, 5'b01001, 5'b10100, 5'b10101, 5'b01010, 5'b01011, 5'b01110, 5'b01111,
          5'b10010, 5'b10011, 5'b10110, 5'b10111, 5'b11010, 5'b11011, 5'b11100, 5'b11101};
    return t[v];
  endfunction

  // decoded nibble, or 5'h10 for an invalid code
  function automatic logic [4:0] dec5(input logic [4:0] code);
    for (int v = 0; v < 16; v++) if (enc(4'(v)) == code) return {1'b0, 4'(v)};
    return 5'h10;
  endfunction

  function automatic logic [31:0] crc_ref(input int n);
    logic [31:0] c = 32'hFFFFFFFF;
    for (int j = 0; j < n; j++)
      for (int b = 0; b < 8; b++)
        if (c[0] ^ payload[j][b]) c = (c >> 1) ^ 32'hEDB88320;
        else                      c = c >> 1;
    return c;
  endfunction

  task automatic push5(input logic [4:0] code);
    for (int b = 0; b < 5; b++) exp_bits.push_back(code[b]);
  endtask

  // expected bit list and per-cycle line level after the start edge
  task automatic build_model(input int n, input int k);
    logic [31:0] tx;
    logic lvl;
    exp_bits.delete();
    exp_lvl.delete();
    for (int i = 0; i < 64; i++) exp_bits.push_back((i % 2) == 1);
    push5(K_SYNC1); push5(K_SYNC1); push5(K_SYNC1); push5(K_SYNC2);
    for (int j = 0; j < k; j++) begin
      push5(enc(payload[j][3:0]));
      push5(enc(payload[j][7:4]));
    end
    if (k < n) push5(K_EOP);
    else begin
      tx = ~crc_ref(n);
      for (int q = 0; q < 8; q++) push5(enc(tx[4*q +: 4]));
      push5(K_EOP);
    end
    lvl = 1'b0;
    foreach (exp_bits[i]) begin
      lvl = !lvl;
      for (int o = 0; o < B; o++) begin
        if (o == H && exp_bits[i]) lvl = !lvl;
        exp_lvl.push_back(lvl);
      end
    end
    if (lvl) for (int o = 0; o < H; o++) exp_lvl.push_back(1'b1);
    for (int o = 0; o < H; o++) exp_lvl.push_back(1'b0);
  endtask

  task automatic drive_src(input int idx, input int n, input int k);
    bus.data_valid = (idx < k);
    bus.data_in    = (idx < k) ? payload[idx] : 8'($urandom);
    bus.data_last  = (idx == n - 1);
  endtask

  function automatic logic dec_bit(input int i);
    return obs[i*B] != obs[i*B + H];
  endfunction

  function automatic logic [4:0] get5(input int pos);
    logic [4:0] c;
    for (int b = 0; b < 5; b++) c[b] = dec_bit(pos + b);
    return c;
  endfunction

  // send one frame of n bytes (source stalls after k); limit >= 0 stops observing early
  task automatic run_frame(input int n, input int k, input int sbusy_at, input int limit);
    int total, ncyc, idx, mm_out, mm_oe, mm_busy, mm_rdy, mm_und, rdy_cnt, und_cnt, oe_len, bad, pos;
    logic e_oe, e_out, e_rdy, e_und, rdy_seen;
    logic [4:0] lo5, hi5;
    logic [31:0] val;
    build_model(n, k);
    total = exp_lvl.size();
    obs.delete();
    {mm_out, mm_oe, mm_busy, mm_rdy, mm_und, rdy_cnt, und_cnt, oe_len} = '0;
    idx = 0;
    drive_src(idx, n, k);
    chk("pre_start_low", {cc_out, cc_oe, bus.busy}, 3'b000);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    ncyc = (limit >= 0) ? limit : total + 4;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      e_oe  = (c < total);
      e_out = (c < total) ? exp_lvl[c] : 1'b0;
      e_rdy = (c >= 84*B) && ((c - 84*B) % (10*B) == 0) && ((c - 84*B) / (10*B) < k);
      e_und = (k < n) && (c == (84 + 10*k) * B);
      if (cc_out !== e_out) mm_out++;
      if (cc_oe !== e_oe) mm_oe++;
      if (bus.busy !== e_oe) mm_busy++;
      if (bus.data_ready !== e_rdy) mm_rdy++;
      if (bus.underrun !== e_und) mm_und++;
      if (bus.data_ready === 1'b1) rdy_cnt++;
      if (bus.underrun === 1'b1) und_cnt++;
      if (cc_oe === 1'b1) oe_len++;
      obs.push_back(cc_out);
      rdy_seen = (bus.data_ready === 1'b1);
      @(posedge clk); #1;
      if (rdy_seen && idx < 15) begin
        idx++;
        drive_src(idx, n, k);
      end
      bus.start = (c == sbusy_at);
    end
    bus.start = 1'b0;
    chk("first_edge_rise", obs[0], 1'b1);
    chk("cc_out_wave_mismatches", mm_out, 0);
    chk("cc_oe_wave_mismatches", mm_oe, 0);
    chk("busy_wave_mismatches", mm_busy, 0);
    chk("data_ready_mismatches", mm_rdy, 0);
    chk("underrun_mismatches", mm_und, 0);
    if (limit < 0) begin
      chk("frame_len_cycles", oe_len, total);
      chk("ready_pulses", rdy_cnt, k);
      chk("underrun_pulses", und_cnt, (k < n) ? 1 : 0);
      bad = 0;
      for (int i = 0; i < 64; i++) if (dec_bit(i) !== ((i % 2) == 1)) bad++;
      chk("preamble_bits", bad, 0);
      chk("sop_codes", {get5(64), get5(69), get5(74), get5(79)}, {K_SYNC1, K_SYNC1, K_SYNC1, K_SYNC2});
      for (int j = 0; j < k; j++) begin
        lo5 = dec5(get5(84 + 10*j));
        hi5 = dec5(get5(89 + 10*j));
        chk($sformatf("payload_byte%0d", j), {hi5, lo5}, {1'b0, payload[j][7:4], 1'b0, payload[j][3:0]});
      end
      pos = 84 + 10*k;
      if (k == n) begin
        bad = 0;
        for (int q = 0; q < 8; q++) begin
          lo5 = dec5(get5(pos + 5*q));
          if (lo5[4]) bad++;
          val[4*q +: 4] = lo5[3:0];
        end
        last_crc_dec = val;
        chk("crc_field", {bad[0], val}, {1'b0, ~crc_ref(n)});
        pos = pos + 40;
      end
      chk("eop_code", get5(pos), K_EOP);
    end
  endtask

  initial begin
    int n;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.data_in = 8'h00;
    bus.data_valid = 1'b0;
    bus.data_last = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_cc_out", cc_out, 1'b0);
    chk("reset_cc_oe", cc_oe, 1'b0);
    chk("reset_busy", bus.busy, 1'b0);
    chk("reset_data_ready", bus.data_ready, 1'b0);
    chk("reset_underrun", bus.underrun, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk); #1;

    // two-byte frame, with a start pulse mid-frame that must be ignored
    payload[0] = 8'h41; payload[1] = 8'h10;
    run_frame(2, 2, 3000, -1);

    // CRC check vector "123456789"
    for (int j = 0; j < 9; j++) payload[j] = 8'h31 + 8'(j);
    run_frame(9, 9, -1, -1);
    chk("crc_vector", last_crc_dec, 32'hCBF43926);

    // random payload
    n = $urandom_range(1, 3);
    for (int j = 0; j < n; j++) payload[j] = 8'($urandom);
    run_frame(n, n, -1, -1);

    // underrun after the first of three bytes
    for (int j = 0; j < 3; j++) payload[j] = 8'($urandom);
    run_frame(3, 1, -1, -1);

    // reset in the middle of the first data byte
    run_frame(3, 3, -1, (84 + 5) * B + 10);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_mid_cc_out", cc_out, 1'b0);
    chk("rst_mid_cc_oe", cc_oe, 1'b0);
    chk("rst_mid_busy", bus.busy, 1'b0);
    chk("rst_mid_data_ready", bus.data_ready, 1'b0);
    chk("rst_mid_underrun", bus.underrun, 1'b0);
    repeat (3) @(posedge clk); #1;

    // clean frame after reset
    for (int j = 0; j < 2; j++) payload[j] = 8'($urandom);
    run_frame(2, 2, -1, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
